// File: rtl/kogge_stone_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, computed as a + ~b + ~bin with a flow-controlled pipe.
// Define KS_SUB_FLAGS_EN to add registered zero (zf) and signed-overflow (vf) flags.
module kogge_stone_subtractor_pipe #(
  parameter int DW   = 16,
  parameter int PIPE = 1,
  parameter int LVL  = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] diff,
  output logic          bout
`ifdef KS_SUB_FLAGS_EN
  ,
  output logic          zf,
  output logic          vf
`endif
);

  logic          w_stall;
  logic          w_adv;
  logic [DW-1:0] w_p0;
  logic [DW-1:0] w_g0;

  assign w_stall  = out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = ~w_stall;

  // The carry-in (~bin) is folded into bit 0's generate so prefix G[i] is the carry out of bit i.
  assign w_p0 = a ^ ~b;
  always_comb begin
    w_g0    = a & ~b;
    w_g0[0] = w_g0[0] | (w_p0[0] & ~bin);
  end

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int SPAN = 1 << k;

    logic [DW-1:0] w_gIn, w_pIn, w_sIn;
    logic [DW-1:0] w_gNx, w_pNx;
    logic [DW-1:0] w_gOut, w_pOut, w_sOut;
    logic          w_cIn, w_vIn, w_cOut, w_vOut;
`ifdef KS_SUB_FLAGS_EN
    logic          w_aIn, w_bIn, w_aOut, w_bOut;
`endif

    if (k == 0) begin : g_src
      assign w_gIn = w_g0;
      assign w_pIn = w_p0;
      assign w_sIn = w_p0;
      assign w_cIn = ~bin;
      assign w_vIn = in_valid & in_ready;
`ifdef KS_SUB_FLAGS_EN
      assign w_aIn = a[DW-1];
      assign w_bIn = b[DW-1];
`endif
    end else begin : g_src
      assign w_gIn = g_lvl[k-1].w_gOut;
      assign w_pIn = g_lvl[k-1].w_pOut;
      assign w_sIn = g_lvl[k-1].w_sOut;
      assign w_cIn = g_lvl[k-1].w_cOut;
      assign w_vIn = g_lvl[k-1].w_vOut;
`ifdef KS_SUB_FLAGS_EN
      assign w_aIn = g_lvl[k-1].w_aOut;
      assign w_bIn = g_lvl[k-1].w_bOut;
`endif
    end

    // Below 2*SPAN the low operand is already a complete group from bit 0, so only G matters (grey cell).
    always_comb begin
      w_gNx = w_gIn;
      w_pNx = w_pIn;
      for (int i = SPAN; i < DW; i++) begin
        w_gNx[i] = w_gIn[i] | (w_pIn[i] & w_gIn[i-SPAN]);
        if (i >= 2 * SPAN) w_pNx[i] = w_pIn[i] & w_pIn[i-SPAN];
        else               w_pNx[i] = 1'b0;
      end
    end

    if (PIPE != 0) begin : g_reg
      logic [DW-1:0] r_g, r_p, r_s;
      logic          r_c, r_v;
`ifdef KS_SUB_FLAGS_EN
      logic          r_a, r_b;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_g <= '0;
          r_p <= '0;
          r_s <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
          r_a <= 1'b0;
          r_b <= 1'b0;
`endif
        end else if (w_adv) begin
          r_g <= w_gNx;
          r_p <= w_pNx;
          r_s <= w_sIn;
          r_c <= w_cIn;
          r_v <= w_vIn;
`ifdef KS_SUB_FLAGS_EN
          r_a <= w_aIn;
          r_b <= w_bIn;
`endif
        end
      end

      assign w_gOut = r_g;
      assign w_pOut = r_p;
      assign w_sOut = r_s;
      assign w_cOut = r_c;
      assign w_vOut = r_v;
`ifdef KS_SUB_FLAGS_EN
      assign w_aOut = r_a;
      assign w_bOut = r_b;
`endif
    end else begin : g_comb
      assign w_gOut = w_gNx;
      assign w_pOut = w_pNx;
      assign w_sOut = w_sIn;
      assign w_cOut = w_cIn;
      assign w_vOut = w_vIn;
`ifdef KS_SUB_FLAGS_EN
      assign w_aOut = w_aIn;
      assign w_bOut = w_bIn;
`endif
    end
  end

  logic [DW-1:0] w_gL, w_sL, w_carry, w_diffNx;
  logic          w_cL, w_vL, w_boutNx, w_unusedP;

  assign w_gL      = g_lvl[LVL-1].w_gOut;
  assign w_sL      = g_lvl[LVL-1].w_sOut;
  assign w_cL      = g_lvl[LVL-1].w_cOut;
  assign w_vL      = g_lvl[LVL-1].w_vOut;
  assign w_unusedP = ^g_lvl[LVL-1].w_pOut;
  assign w_carry   = {w_gL[DW-2:0], w_cL};
  assign w_diffNx  = w_sL ^ w_carry;
  assign w_boutNx  = ~w_gL[DW-1];

  logic          r_outValid, r_bout;
  logic [DW-1:0] r_diff;
`ifdef KS_SUB_FLAGS_EN
  logic          r_zf, r_vf;
  logic          w_zfNx, w_vfNx;
  assign w_zfNx = ~|w_diffNx;
  assign w_vfNx = (g_lvl[LVL-1].w_aOut ^ g_lvl[LVL-1].w_bOut) &
                  (g_lvl[LVL-1].w_aOut ^ w_diffNx[DW-1]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
      r_zf       <= 1'b0;
      r_vf       <= 1'b0;
`endif
    end else if (w_adv) begin
      r_outValid <= w_vL;
      r_diff     <= w_diffNx;
      r_bout     <= w_boutNx;
`ifdef KS_SUB_FLAGS_EN
      r_zf       <= w_zfNx;
      r_vf       <= w_vfNx;
`endif
    end
  end

  assign out_valid = r_outValid;
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef KS_SUB_FLAGS_EN
  assign zf        = r_zf;
  assign vf        = r_vf;
`endif

endmodule

// File: tb/tb_kogge_stone_subtractor_pipe.sv
// Testbench for kogge_stone_subtractor_pipe: directed and randomized beats checked against an arithmetic model.
// Flag checks are included when KS_SUB_FLAGS_EN is defined.
module tb_kogge_stone_subtractor_pipe;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid, inReady, binIn, outValid, outReady, bout;
  logic [DW-1:0] aIn, bIn, diff;
  logic          p0InValid, p0InReady, p0Bin, p0OutValid, p0OutReady, p0Bout;
  logic [DW-1:0] p0A, p0B, p0Diff;
`ifdef KS_SUB_FLAGS_EN
  logic          zf, vf, p0Zf, p0Vf;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW+2:0] expQ[$];
  logic [DW-1:0] heldDiff;
  bit            prevStall = 0;

  always #5 clk = ~clk;

  kogge_stone_subtractor_pipe #(.DW(DW), .PIPE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(aIn), .b(bIn), .bin(binIn), .out_valid(outValid), .out_ready(outReady),
    .diff(diff), .bout(bout)
`ifdef KS_SUB_FLAGS_EN
    , .zf(zf), .vf(vf)
`endif
  );

  kogge_stone_subtractor_pipe #(.DW(DW), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(p0InValid), .in_ready(p0InReady),
    .a(p0A), .b(p0B), .bin(p0Bin), .out_valid(p0OutValid), .out_ready(p0OutReady),
    .diff(p0Diff), .bout(p0Bout)
`ifdef KS_SUB_FLAGS_EN
    , .zf(p0Zf), .vf(p0Vf)
`endif
  );

  // Expected result packed as {vf, zf, bout, diff}, from plain wide subtraction.
  function automatic logic [DW+2:0] refSub(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic bi);
    logic [DW:0] r;
    logic        z, o;
    r = {1'b0, av} - {1'b0, bv} - {{DW{1'b0}}, bi};
    z = (r[DW-1:0] == '0);
    o = (av[DW-1] != bv[DW-1]) && (av[DW-1] != r[DW-1]);
    return {o, z, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle from a negedge, scores any beat leaving the pipe, then advances to the next negedge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                               input logic bi, input logic ordy);
    logic [DW+2:0] e;
    inValid = v; aIn = av; bIn = bv; binIn = bi; outReady = ordy;
    #1;
    if (outValid && outReady) begin
      if (expQ.size() == 0) checkOutput("spurious out_valid", outValid, 0);
      else begin
        e = expQ.pop_front();
        checkOutput("diff", diff, e[DW-1:0]);
        checkOutput("bout", bout, e[DW]);
`ifdef KS_SUB_FLAGS_EN
        checkOutput("zf", zf, e[DW+1]);
        checkOutput("vf", vf, e[DW+2]);
`endif
      end
    end
    if (outValid && !outReady) begin
      if (prevStall) checkOutput("stall hold diff", diff, heldDiff);
      heldDiff  = diff;
      prevStall = 1;
    end else prevStall = 0;
    if (v && inReady) expQ.push_back(refSub(av, bv, bi));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drainPipe();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) applyStimulus(0, '0, '0, 0, 1);
    checkOutput("drain left beats", expQ.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1; inValid = 0; aIn = '0; bIn = '0; binIn = 0; outReady = 1;
    p0InValid = 0; p0A = '0; p0B = '0; p0Bin = 0; p0OutReady = 1;
    @(negedge clk); @(negedge clk);
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset bout", bout, 0);
    rst = 0;
    #1 checkOutput("in_ready after reset", inReady, 1);
    @(negedge clk);

    // Single beat latency
    inValid = 1; aIn = 16'h1234; bIn = 16'h0234; binIn = 0; outReady = 1;
    expQ.push_back(refSub(16'h1234, 16'h0234, 0));
    @(posedge clk); @(negedge clk);
    inValid = 0;
    n = 1;
    while (!outValid && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checkOutput("latency", n, 5);
    checkOutput("basic diff", diff, 16'h1000);
    checkOutput("basic bout", bout, 0);
    drainPipe();

    // Borrow and boundary beats
    applyStimulus(1, 16'h0000, 16'h0001, 0, 1);
    applyStimulus(1, 16'h5555, 16'h5555, 1, 1);
    applyStimulus(1, 16'hA5A5, 16'hA5A5, 0, 1);
    applyStimulus(1, 16'h0000, 16'h0000, 1, 1);
    applyStimulus(1, 16'hFFFF, 16'h0000, 0, 1);
    applyStimulus(1, 16'h0000, 16'hFFFF, 1, 1);
    drainPipe();

    // Stream of 8 beats with a 3-cycle stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        for (int s = 0; s < 3; s++) begin
          inValid = 1; outReady = 0;
          #1;
          checkOutput("in_ready during stall", inReady, 0);
          checkOutput("out_valid during stall", outValid, 1);
          applyStimulus(1, 16'(i * 16'h1111), 16'(i), 0, 0);
        end
      end
      applyStimulus(1, 16'(i * 16'h1111), 16'(i), 0, 1);
    end
    drainPipe();

    // PIPE=0 instance: single-cycle latency
    p0InValid = 1; p0A = 16'hFFFF; p0B = 16'h0000; p0Bin = 0; p0OutReady = 1;
    @(posedge clk); @(negedge clk);
    p0InValid = 0;
    checkOutput("pipe0 out_valid", p0OutValid, 1);
    checkOutput("pipe0 diff", p0Diff, 16'hFFFF);
    checkOutput("pipe0 bout", p0Bout, 0);
    @(posedge clk); @(negedge clk);
    checkOutput("pipe0 bubble", p0OutValid, 0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 80; i++)
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    drainPipe();

`ifdef KS_SUB_FLAGS_EN
    applyStimulus(1, 16'h8000, 16'h0001, 0, 1);
    applyStimulus(1, 16'h4000, 16'h4000, 0, 1);
    n = 0;
    while (!outValid && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checkOutput("flag beat diff", diff, 16'h7FFF);
    checkOutput("flag beat vf", vf, 1);
    checkOutput("flag beat zf", zf, 0);
    drainPipe();
`endif

    // Reset with beats in flight
    applyStimulus(1, 16'h1234, 16'h0234, 0, 1);
    applyStimulus(1, 16'h7777, 16'h0007, 0, 1);
    applyStimulus(1, 16'h0F0F, 16'h0101, 1, 1);
    applyStimulus(0, '0, '0, 0, 1);
    inValid = 0; outReady = 0;
    @(posedge clk); @(negedge clk);
    checkOutput("pre-reset out_valid", outValid, 1);
    rst = 1;
    #1;
    checkOutput("mid reset out_valid", outValid, 0);
    checkOutput("mid reset diff", diff, 0);
    checkOutput("mid reset bout", bout, 0);
`ifdef KS_SUB_FLAGS_EN
    checkOutput("mid reset zf", zf, 0);
    checkOutput("mid reset vf", vf, 0);
`endif
    @(posedge clk); @(negedge clk);
    rst = 0;
    expQ.delete();
    prevStall = 0;
    #1 checkOutput("in_ready after release", inReady, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("no beat after reset", outValid, 0);
      applyStimulus(0, '0, '0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kogge_stone_subtractor_pipe.md
Name: kogge_stone_subtractor_pipe

Overview:
Pipelined parallel-prefix subtractor. Computes DIFF = A - B - BIN and produces a borrow-out. Uses the team's Kogge-Stone prefix network on A + ~B + ~BIN, with optional pipeline registers between prefix levels. Sits in the datapath next to the combinational adder and feeds comparison and decrement paths that need a registered, flow-controlled result.

Parameters:
DW, 16, operand and result width; power of two, at least 4.
PIPE, 1, 1 = register after every prefix level; 0 = single output register only.
LVL, $clog2(DW), number of prefix levels (derived; do not override).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
a  input  DW  minuend.
b  input  DW  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
diff  output  DW  (a - b - bin) mod 2^DW.
bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Arithmetic: p_i = a_i ^ ~b_i, g_i = a_i & ~b_i, carry-in = ~bin.
- Prefix combine: black cell (G = Gh | Ph&Gl, P = Ph&Pl); grey cell where only G is needed.
- Level k combines span 2^k.
- diff_i = p_i ^ c_i. bout = ~c_DW.
- Latency: L = PIPE ? LVL+1 : 1 cycles from the accepting edge (in_valid & in_ready) to the result on diff/bout with out_valid=1. DW=16, PIPE=1 gives L=5.
- Each pipeline stage holds a valid bit, its G/P vector, the level-0 p vector (needed for the sum), and carry-in.
- Stall rule: stall = out_valid & ~out_ready. On stall, every stage register holds its value.
- in_ready = ~stall, combinational. No bubble collapsing: the whole pipe advances or freezes together.
- Throughput: one beat per cycle while out_ready=1.
- diff and bout hold stable while out_valid=1 and out_ready=0.
- A beat presented with in_valid=0 inserts a bubble (valid bit 0). Data in bubble stages is don't-care but stays deterministic.
- Simultaneous accept and drain in the same cycle is legal and must not lose or duplicate beats.
- Reset (async assert, takes effect immediately):
  - all valid bits 0, out_valid=0;
  - diff=0, bout=0, all G/P/p registers 0.
  - Reset mid-operation drops all in-flight beats; no output appears after release.
- Release: in_ready=1 in the first cycle after rst deasserts.
- Boundary cases:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all ones, bout=1.
  - a=all ones, b=0, bin=0 gives diff=all ones, bout=0.

Optional Feature:
Macro KS_SUB_FLAGS_EN.
- Defined: adds outputs zf (1 bit, diff==0) and vf (1 bit, signed overflow = (a[DW-1]^b[DW-1]) & (a[DW-1]^diff[DW-1])).
  - a[DW-1] and b[DW-1] are carried down the pipe alongside the data.
  - Both flags are registered with diff, hold under stall, and reset to 0.
- Not defined: ports zf and vf do not exist, and no sign-bit registers are instantiated.

Test Plan:
- Basic: DW=16, PIPE=1, single beat a=0x1234, b=0x0234, bin=0 -> exactly 5 cycles later out_valid=1, diff=0x1000, bout=0.
- Borrow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Also a=0x5555, b=0x5555, bin=1 -> diff=0xFFFF, bout=1.
- Stream with backpressure: 8 back-to-back beats a=i*0x1111, b=i, bin=0; hold out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 during the stall.
  - All 8 results arrive in order, none lost or duplicated, and diff stays stable while stalled.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle.
  - out_valid=0, diff=0, bout=0 immediately on assert.
  - No result emerges after release; in_ready=1 on the first cycle after release.
- PIPE=0: a=0xFFFF, b=0x0000, bin=0 -> 1-cycle latency, diff=0xFFFF, bout=0.
- KS_SUB_FLAGS_EN:
  - a=0x8000, b=0x0001 -> diff=0x7FFF, vf=1, zf=0.
  - a=0x4000, b=0x4000 -> diff=0x0000, zf=1, vf=0.
